// File: rtl/counter_u_d_dir_decoder.sv
// counter_u_d_dir_decoder
//
// This block watches the 2-bit up/down counter and works out which command moved
// it. It samples `count` on every rising clock edge. It compares each sample with
// the previous one and reports the result:
//   - up, down or hold, in the same `enable` encoding the counter uses;
//   - an illegal two-step jump, flagged as a fault;
//   - a signed, wrapping position built from the legal steps.
//
// Parameters
//   POS_W   width of the signed position accumulator (minimum 3)
//   ERR_W   width of the saturating illegal-jump counter
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   count    in   observed counter value
//   clear    in   synchronous soft clear, same effect as reset
//   dir      out  decoded command: 01 up, 10 down, 00 hold, 11 illegal jump
//   step     out  one-cycle pulse per legal +/-1 transition
//   pos      out  two's-complement position accumulator
//   err      out  sticky illegal-jump flag
//   err_cnt  out  illegal-jump count, saturating at all-ones
//
// Every output is registered. No combinational path runs from `count` to any
// output.

module counter_u_d_dir_decoder #(
  parameter int unsigned POS_W = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       count,
  input  logic             clear,
  output logic [1:0]       dir,
  output logic             step,
  output logic [POS_W-1:0] pos,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] DirHold = 2'b00;
  localparam logic [1:0] DirUp   = 2'b01;
  localparam logic [1:0] DirDown = 2'b10;
  localparam logic [1:0] DirJump = 2'b11;

  typedef enum logic [1:0] {
    StInit,
    StTrack,
    StFault
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       prev_q, prev_d;
  logic [1:0]       dir_q, dir_d;
  logic             step_q, step_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Modulo-4 distance between samples: 1 = up, 3 = down, 2 = illegal jump.
  logic [1:0] delta;
  assign delta = count - prev_q;

  // clear has exactly the same effect as reset on every register.
  logic flush;
  assign flush = reset | clear;

  // State register
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  state_d = StTrack;
      StTrack: if (delta == 2'd2) state_d = StFault;
      StFault: state_d = StFault;  // only flush leaves FAULT
      default: state_d = StInit;
    endcase
  end

  // Datapath next-state / registered-output logic
  always_comb begin
    prev_d    = count;
    dir_d     = DirHold;
    step_d    = 1'b0;
    pos_d     = pos_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StInit: begin
        // First sample only seeds prev; there is nothing to compare against yet.
      end
      StTrack, StFault: begin
        unique case (delta)
          2'd0: begin
            dir_d = DirHold;
          end
          2'd1: begin
            dir_d  = DirUp;
            step_d = 1'b1;
            if (state_q == StTrack) pos_d = pos_q + POS_W'(1);
          end
          2'd3: begin
            dir_d  = DirDown;
            step_d = 1'b1;
            if (state_q == StTrack) pos_d = pos_q - POS_W'(1);
          end
          2'd2: begin
            dir_d = DirJump;
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          default: begin
            // X/Z on count: the delta is unknown, so propagate that to dir.
            dir_d  = 2'bxx;
            step_d = 1'bx;
          end
        endcase
      end
      default: begin
        dir_d = DirHold;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      prev_q    <= 2'b00;
      dir_q     <= DirHold;
      step_q    <= 1'b0;
      pos_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      prev_q    <= prev_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign dir     = dir_q;
  assign step    = step_q;
  assign pos     = pos_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_counter_u_d_dir_decoder.sv
// Directed, table-driven bench for counter_u_d_dir_decoder.
// It uses POS_W = 3 and ERR_W = 2, so signed wrap and saturation are reachable.

module tb_counter_u_d_dir_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] count = 2'b00;
  logic [1:0] dir;
  logic       step;
  logic [2:0] pos;
  logic       err;
  logic [1:0] err_cnt;

  counter_u_d_dir_decoder #(
    .POS_W(3),
    .ERR_W(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .count  (count),
    .clear  (clear),
    .dir    (dir),
    .step   (step),
    .pos    (pos),
    .err    (err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [1:0] cnt;
    logic [1:0] e_dir;
    logic       e_step;
    logic [2:0] e_pos;
    logic       e_err;
    logic [1:0] e_ecnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic c, input logic [1:0] cn,
                     input logic [1:0] d, input logic s, input logic [2:0] p,
                     input logic e, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.clr = c; v.cnt = cn;
    v.e_dir = d; v.e_step = s; v.e_pos = p; v.e_err = e; v.e_ecnt = ec;
    vecs.push_back(v);
  endtask

  // Apply inputs, clock one edge, sample 1 time unit after it.
  task automatic apply(input logic r, input logic c, input logic [1:0] cn);
    reset = r;
    clear = c;
    count = cn;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] d, input logic s,
                       input logic [2:0] p, input logic e, input logic [1:0] ec);
    n_vec++;
    if (dir !== d || step !== s || pos !== p || err !== e || err_cnt !== ec) begin
      n_bad++;
      $display("FAIL %s: got dir=%b step=%b pos=%b err=%b err_cnt=%b, want dir=%b step=%b pos=%b err=%b err_cnt=%b",
               name, dir, step, pos, err, err_cnt, d, s, p, e, ec);
    end
  endtask

  initial begin
    int pulses;

    // Reset and hold: reset 2 cycles, then count=10 for 5 cycles.
    add(1, 0, 2'b10, 2'b00, 0, 3'b000, 0, 2'd0);
    add(1, 0, 2'b10, 2'b00, 0, 3'b000, 0, 2'd0);
    for (int i = 0; i < 5; i++) add(0, 0, 2'b10, 2'b00, 0, 3'b000, 0, 2'd0);

    // Up wrap: 00 captured in INIT, then 01,10,11,00,01, then one hold.
    add(1, 0, 2'b00, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b01, 2'b01, 1, 3'b001, 0, 2'd0);
    add(0, 0, 2'b10, 2'b01, 1, 3'b010, 0, 2'd0);
    add(0, 0, 2'b11, 2'b01, 1, 3'b011, 0, 2'd0);
    add(0, 0, 2'b00, 2'b01, 1, 3'b100, 0, 2'd0);
    add(0, 0, 2'b01, 2'b01, 1, 3'b101, 0, 2'd0);
    add(0, 0, 2'b01, 2'b00, 0, 3'b101, 0, 2'd0);

    // Down and signed wrap: 00,11,10,01,00,11 -> pos = -5 = 011.
    add(1, 0, 2'b00, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b11, 2'b10, 1, 3'b111, 0, 2'd0);
    add(0, 0, 2'b10, 2'b10, 1, 3'b110, 0, 2'd0);
    add(0, 0, 2'b01, 2'b10, 1, 3'b101, 0, 2'd0);
    add(0, 0, 2'b00, 2'b10, 1, 3'b100, 0, 2'd0);
    add(0, 0, 2'b11, 2'b10, 1, 3'b011, 0, 2'd0);

    // Illegal jump at pos=2 (01->11), then steps in FAULT leave pos frozen.
    add(1, 0, 2'b11, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b11, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b00, 2'b01, 1, 3'b001, 0, 2'd0);
    add(0, 0, 2'b01, 2'b01, 1, 3'b010, 0, 2'd0);
    add(0, 0, 2'b11, 2'b11, 0, 3'b010, 1, 2'd1);
    add(0, 0, 2'b00, 2'b01, 1, 3'b010, 1, 2'd1);
    add(0, 0, 2'b11, 2'b10, 1, 3'b010, 1, 2'd1);
    add(0, 0, 2'b00, 2'b01, 1, 3'b010, 1, 2'd1);

    // Clear collision: clear with a 00->10 jump, then INIT, then tracking resumes.
    add(0, 1, 2'b10, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b11, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b00, 2'b01, 1, 3'b001, 0, 2'd0);

    // Saturation: 5 illegal jumps with ERR_W=2, then a hold.
    add(1, 0, 2'b00, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 2'd0);
    add(0, 0, 2'b10, 2'b11, 0, 3'b000, 1, 2'd1);
    add(0, 0, 2'b00, 2'b11, 0, 3'b000, 1, 2'd2);
    add(0, 0, 2'b10, 2'b11, 0, 3'b000, 1, 2'd3);
    add(0, 0, 2'b00, 2'b11, 0, 3'b000, 1, 2'd3);
    add(0, 0, 2'b10, 2'b11, 0, 3'b000, 1, 2'd3);
    add(0, 0, 2'b10, 2'b00, 0, 3'b000, 1, 2'd3);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].clr, vecs[i].cnt);
      check($sformatf("vec%0d", i), vecs[i].e_dir, vecs[i].e_step, vecs[i].e_pos,
            vecs[i].e_err, vecs[i].e_ecnt);
    end

    // Hand-written: reset mid-run discards prev. The pre-reset prev is 10. After
    // reset, 00 seeds INIT, so the following 01 is a single up step, not a jump.
    apply(1, 0, 2'b01);
    apply(0, 0, 2'b00);
    apply(0, 0, 2'b01);
    check("reset_discards_prev", 2'b01, 1'b1, 3'b001, 1'b0, 2'd0);

    // Hand-written: count pulses over 8 back-to-back up steps (wraps pos 001->001).
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      apply(0, 0, 2'(i + 2));
      if (step === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 8 || pos !== 3'b001) begin
      n_bad++;
      $display("FAIL up_run8: got pulses=%0d pos=%b, want pulses=8 pos=001", pulses, pos);
    end

    // Hand-written: clear while in TRACK with nonzero pos returns everything to zero.
    apply(0, 1, 2'b11);
    check("clear_in_track", 2'b00, 1'b0, 3'b000, 1'b0, 2'd0);
    apply(0, 0, 2'b01);
    check("init_after_clear", 2'b00, 1'b0, 3'b000, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_u_d_dir_decoder.md
# counter_u_d_dir_decoder

Receive-side companion to the team's 2-bit up/down Moore counter. Samples the counter's 2-bit `count` bus every clock and recovers the command that produced each transition: up, down or hold, using the counter's own `enable` encoding. Flags illegal two-step jumps and maintains a signed wrapping position accumulator. Sits downstream of the counter, or of any 2-bit Gray-free modulo-4 source, as a checker and position tracker.

## Interface
- `POS_W`, default 8: width of the signed position accumulator, minimum 3.
- `ERR_W`, default 4: width of the saturating illegal-jump counter.

- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: synchronous, active-high; clears all state on the next `clk` edge.
- `count`, input, 2: observed counter value, sampled every rising edge.
- `clear`, input, 1: synchronous soft clear. Effect is identical to `reset` on every register; `reset` has priority.
- `dir`, output, 2: decoded command. 01 = up, 10 = down, 00 = hold, 11 = illegal jump.
- `step`, output, 1: one-cycle pulse for a legal ±1 transition.
- `pos`, output, `POS_W`: two's-complement position, +1 per up step, −1 per down step.
- `err`, output, 1: sticky illegal-jump flag.
- `err_cnt`, output, `ERR_W`: number of illegal jumps, saturating at all-ones.

## Operation
- Internal registers:
  - `prev[1:0]`: last sampled `count`.
  - `state`: one of INIT, TRACK, FAULT.
- Delta per edge: d = (`count` − `prev`) mod 4, computed as a 2-bit subtraction.
- Reset or `clear` values:
  - state = INIT, `prev` = 00.
  - `dir` = 00, `step` = 0, `pos` = 0, `err` = 0, `err_cnt` = 0.
- INIT:
  - Captures `prev` ← `count`.
  - Outputs hold their reset values; no delta is evaluated.
  - Next state is TRACK unconditionally.
- TRACK, every edge:
  - `prev` ← `count`.
  - d=0: `dir` = 00, `step` = 0.
  - d=1: `dir` = 01, `step` = 1, `pos` += 1.
  - d=3: `dir` = 10, `step` = 1, `pos` −= 1.
  - d=2: `dir` = 11, `step` = 0, `pos` unchanged, `err` ← 1, `err_cnt` += 1 (saturating). Next state is FAULT.
- FAULT:
  - Keeps decoding: `prev` updates, and `dir` and `step` follow the same rules as TRACK.
  - `pos` is frozen.
  - Further d=2 events increment `err_cnt` (saturating) and drive `dir` = 11.
  - Exits only via `clear` or `reset`, both of which lead to INIT.
- `pos` arithmetic:
  - Modulo 2^`POS_W`.
  - Up from 0111…1 wraps to 1000…0.
  - Down from 1000…0 wraps to 0111…1.
  - No overflow flag.
- Counter wrap 11→00 is d=1 (up). Counter wrap 00→11 is d=3 (down).
- `count` containing X or Z: d is unknown. Simulation must then drive `dir` = xx. Verification does not check this case.

## Timing
- All outputs are registered. There is no combinational path from `count` to any output.
- Latency: a transition between samples at edges N−1 and N appears on `dir`, `step`, `pos` and `err` after edge N, and is valid during cycle N+1.
- First evaluated delta: `count` at edge 0 is captured in INIT. The earliest decoded transition is between edges 0 and 1, visible after edge 1.
- `step` is high for exactly one cycle per legal step. Consecutive steps produce back-to-back pulses.
- `clear` asserted together with a d=2 event: clear wins, and state is INIT after the edge.
- `reset` mid-operation discards `prev`. The next sample is not compared against any pre-reset value.
- `err_cnt` at all-ones plus another illegal jump stays at all-ones; `dir` still shows 11.

## Test plan
- **Reset and hold.** Apply `reset` for 2 cycles, then hold `count` = 10 for 5 cycles. Required: `pos` = 0, `dir` = 00, `step` = 0 and `err` = 0 throughout.
- **Up wrap.** Drive `count` 00,01,10,11,00,01 on consecutive edges after INIT. Required: 5 `step` pulses, `dir` = 01 each time, final `pos` = 5.
- **Down and signed wrap.** With `POS_W` = 3, drive `count` 00,11,10,01,00,11 (5 down steps). Required: `pos` = −5, i.e. 011 (wrapped from −4 = 100 to 011), and `dir` = 10 on each step.
- **Illegal jump.** At `pos` = 2, drive `count` 01→11. Required: `dir` = 11, `err` = 1, `err_cnt` = 1, `pos` stays 2. A subsequent up step gives `step` = 1 with `pos` still 2.
- **Clear collision.** In FAULT, assert `clear` on the same edge as another 00→10 jump. Required: after the edge, all outputs are zero and the state is INIT; the next edge produces no step.
- **Saturation.** With `ERR_W` = 2, apply 5 illegal jumps. Required: `err_cnt` = 11 and `dir` = 11 on the last jump.
